// File: rtl/gpio_bank_if.sv
// gpio_bank_if: single-slot memory bus connecting a top-level decoder (master)
// to one peripheral (slave).
interface gpio_bank_if;
    logic [31:0] address_in;
    logic        sel_in;
    logic        read_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;

    modport master (
        output address_in, sel_in, read_in, write_mask_in, write_value_in,
        input  read_value_out, ready_out
    );

    modport slave (
        input  address_in, sel_in, read_in, write_mask_in, write_value_in,
        output read_value_out, ready_out
    );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped bank of WIDTH pins with per-pin direction, output data,
// synchronised and debounced inputs, rise/fall edge capture and a level interrupt.
module gpio_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DB_W      = 16,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    parameter logic [WIDTH-1:0] RESET_DIR = '0
) (
    input  logic             clk,
    input  logic             reset,
    gpio_bank_if.slave       bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_out
);
    typedef enum logic [2:0] {
        REG_DATA_OUT    = 3'd0,
        REG_DIR         = 3'd1,
        REG_DATA_IN     = 3'd2,
        REG_EDGE_STATUS = 3'd3,
        REG_RISE_EN     = 3'd4,
        REG_FALL_EN     = 3'd5,
        REG_DEBOUNCE    = 3'd6,
        REG_RESERVED    = 3'd7
    } reg_sel_e;

    reg_sel_e         reg_sel;
    logic             write_en;
    logic [31:0]      lane_mask;
    logic [31:0]      wr_bits;
    logic [31:0]      rd_data;

    logic [WIDTH-1:0] data_out, dir, rise_en, fall_en, edge_status;
    logic [DB_W-1:0]  debounce;

    logic [WIDTH-1:0] sync_meta, sync, db, prev;
    logic [DB_W-1:0]  cnt [WIDTH];
    logic [WIDTH-1:0] db_hit, rise, fall, w1c;

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] mask,
                                          input logic [31:0] bits);
        return (old_val & ~mask) | bits;
    endfunction

    assign reg_sel   = reg_sel_e'(bus.address_in[4:2]);
    assign write_en  = bus.sel_in && (bus.write_mask_in != 4'b0000);
    assign lane_mask = {{8{bus.write_mask_in[3]}}, {8{bus.write_mask_in[2]}},
                        {8{bus.write_mask_in[1]}}, {8{bus.write_mask_in[0]}}};
    assign wr_bits   = bus.write_value_in & lane_mask;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= RESET_OUT;
            dir      <= RESET_DIR;
            rise_en  <= '0;
            fall_en  <= '0;
            debounce <= '0;
        end else if (write_en) begin
            case (reg_sel)
                REG_DATA_OUT: data_out <= WIDTH'(merge(32'(data_out), lane_mask, wr_bits));
                REG_DIR:      dir      <= WIDTH'(merge(32'(dir), lane_mask, wr_bits));
                REG_RISE_EN:  rise_en  <= WIDTH'(merge(32'(rise_en), lane_mask, wr_bits));
                REG_FALL_EN:  fall_en  <= WIDTH'(merge(32'(fall_en), lane_mask, wr_bits));
                REG_DEBOUNCE: debounce <= DB_W'(merge(32'(debounce), lane_mask, wr_bits));
                default: ;
            endcase
        end
    end

    // Compare in DB_W+1 bits so cnt+1 cannot wrap against a maximal threshold.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            db_hit[i] = ({1'b0, cnt[i]} + (DB_W+1)'(1)) >= {1'b0, debounce};
        end
    end

    assign rise = db & ~prev & rise_en;
    assign fall = ~db & prev & fall_en;
    assign w1c  = (write_en && reg_sel == REG_EDGE_STATUS) ? WIDTH'(wr_bits) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta   <= '0;
            sync        <= '0;
            db          <= '0;
            prev        <= '0;
            edge_status <= '0;
            // NOTE: the counters are plain flops, not a RAM, so they take the async reset too.
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync_meta   <= gpio_in;
            sync        <= sync_meta;
            prev        <= db;
            edge_status <= (edge_status & ~w1c) | rise | fall;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (db_hit[i]) begin
                    db[i]  <= sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // NOTE: rd_data gets a default first so no path through the case infers a latch.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA_OUT:    rd_data = 32'(data_out);
            REG_DIR:         rd_data = 32'(dir);
            REG_DATA_IN:     rd_data = 32'(db);
            REG_EDGE_STATUS: rd_data = 32'(edge_status);
            REG_RISE_EN:     rd_data = 32'(rise_en);
            REG_FALL_EN:     rd_data = 32'(fall_en);
            REG_DEBOUNCE:    rd_data = 32'(debounce);
            default:         rd_data = '0;
        endcase
    end

    assign bus.read_value_out = bus.sel_in ? rd_data : '0;
    assign bus.ready_out      = bus.sel_in;

    assign gpio_out = data_out;
    assign gpio_oe  = dir;
    assign irq_out  = |edge_status;

    // Reads have no side effects and only address bits [4:2] decode a register.
    logic unused_bus;
    assign unused_bus = &{1'b0, bus.read_in, bus.address_in[31:5], bus.address_in[1:0]};
endmodule
